// File: rtl/regfile_bank.sv
// Multi-ported register file with write-first bypass, optional zero register
// and a per-register busy scoreboard for outstanding destination reservations.
module regfile_bank #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] a_sel,
    output logic [DATA_W-1:0] a_data,
    output logic              a_busy,
    input  logic [ADDR_W-1:0] b_sel,
    output logic [DATA_W-1:0] b_data,
    output logic              b_busy,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_sel,
    input  logic [DATA_W-1:0] w_data,
    input  logic              x_en,
    input  logic [ADDR_W-1:0] x_sel,
    input  logic [DATA_W-1:0] x_data,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_sel,
    output logic              lock_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              lock_err_q;
    logic              lock_err_d;
    logic              lock_ok;
    logic              lock_cleared;

    // X is applied first so a colliding W overwrites it.
    always_comb begin
        mem_d = mem_q;
        if (x_en) mem_d[x_sel] = x_data;
        if (w_en) mem_d[w_sel] = w_data;
        if (ZERO_R0 != 0) mem_d[0] = '0;
    end

    always_comb begin
        lock_ok      = lock_en && !((ZERO_R0 != 0) && (lock_sel == '0));
        lock_cleared = (w_en && (w_sel == lock_sel)) || (x_en && (x_sel == lock_sel));
        lock_err_d   = lock_ok && busy_q[lock_sel] && !lock_cleared;
    end

    // Writes release a reservation; a same-cycle lock re-reserves it.
    always_comb begin
        busy_d = busy_q;
        if (x_en) busy_d[x_sel] = 1'b0;
        if (w_en) busy_d[w_sel] = 1'b0;
        if (lock_ok) busy_d[lock_sel] = 1'b1;
        if (ZERO_R0 != 0) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            busy_q     <= '0;
            lock_err_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            lock_err_q <= lock_err_d;
        end
    end

    always_comb begin
        a_data = mem_q[a_sel];
        if (BYPASS != 0) begin
            if (w_en && (w_sel == a_sel))      a_data = w_data;
            else if (x_en && (x_sel == a_sel)) a_data = x_data;
        end
        if ((ZERO_R0 != 0) && (a_sel == '0)) a_data = '0;
    end

    always_comb begin
        b_data = mem_q[b_sel];
        if (BYPASS != 0) begin
            if (w_en && (w_sel == b_sel))      b_data = w_data;
            else if (x_en && (x_sel == b_sel)) b_data = x_data;
        end
        if ((ZERO_R0 != 0) && (b_sel == '0)) b_data = '0;
    end

    assign a_busy   = busy_q[a_sel];
    assign b_busy   = busy_q[b_sel];
    assign lock_err = lock_err_q;

endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank: three instances (bypass, no bypass,
// zero register) share one stimulus stream.
module tb_regfile_bank;

    logic        clk;
    logic        rst;
    logic [2:0]  a_sel, b_sel, w_sel, x_sel, lock_sel;
    logic [15:0] w_data, x_data;
    logic        w_en, x_en, lock_en;

    logic [15:0] a_data, b_data, nb_a_data, nb_b_data, z_a_data, z_b_data;
    logic        a_busy, b_busy, nb_a_busy, nb_b_busy, z_a_busy, z_b_busy;
    logic        lock_err, nb_lock_err, z_lock_err;

    int n_checks;
    int n_fail;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    regfile_bank #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .ZERO_R0(0)) u_dut (
        .clk(clk), .rst(rst),
        .a_sel(a_sel), .a_data(a_data), .a_busy(a_busy),
        .b_sel(b_sel), .b_data(b_data), .b_busy(b_busy),
        .w_en(w_en), .w_sel(w_sel), .w_data(w_data),
        .x_en(x_en), .x_sel(x_sel), .x_data(x_data),
        .lock_en(lock_en), .lock_sel(lock_sel), .lock_err(lock_err)
    );

    regfile_bank #(.DATA_W(16), .ADDR_W(3), .BYPASS(0), .ZERO_R0(0)) u_nb (
        .clk(clk), .rst(rst),
        .a_sel(a_sel), .a_data(nb_a_data), .a_busy(nb_a_busy),
        .b_sel(b_sel), .b_data(nb_b_data), .b_busy(nb_b_busy),
        .w_en(w_en), .w_sel(w_sel), .w_data(w_data),
        .x_en(x_en), .x_sel(x_sel), .x_data(x_data),
        .lock_en(lock_en), .lock_sel(lock_sel), .lock_err(nb_lock_err)
    );

    regfile_bank #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .ZERO_R0(1)) u_z (
        .clk(clk), .rst(rst),
        .a_sel(a_sel), .a_data(z_a_data), .a_busy(z_a_busy),
        .b_sel(b_sel), .b_data(z_b_data), .b_busy(z_b_busy),
        .w_en(w_en), .w_sel(w_sel), .w_data(w_data),
        .x_en(x_en), .x_sel(x_sel), .x_data(x_data),
        .lock_en(lock_en), .lock_sel(lock_sel), .lock_err(z_lock_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_en    = 1'b0;
        x_en    = 1'b0;
        lock_en = 1'b0;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        a_sel = 3'd3; b_sel = 3'd3; w_sel = '0; x_sel = '0; lock_sel = '0;
        w_data = '0; x_data = '0;
        w_en = 1'b0; x_en = 1'b0; lock_en = 1'b0;
        step();
        step();
        check("reset_a_data", a_data, 16'h0000);
        check("reset_b_busy", b_busy, 1'b0);
        check("reset_lock_err", lock_err, 1'b0);
        rst = 1'b0;
        step();

        // reg3 written and reserved, then reset lands mid-cycle with a lock pending
        w_en = 1'b1; w_sel = 3'd3; w_data = 16'h3456; lock_en = 1'b1; lock_sel = 3'd3;
        step();
        idle();
        check("pre_rst_a_data", a_data, 16'h3456);
        check("pre_rst_b_busy", b_busy, 1'b1);
        lock_en = 1'b1; lock_sel = 3'd3;
        w_en = 1'b1; w_sel = 3'd3; w_data = 16'h1234;
        rst = 1'b1;
        #1;
        check("async_rst_nb_a_data", nb_a_data, 16'h0000);
        check("async_rst_b_busy", b_busy, 1'b0);
        step();
        idle();
        check("rst_held_a_data", a_data, 16'h0000);
        check("rst_held_a_busy", a_busy, 1'b0);
        check("rst_held_lock_err", lock_err, 1'b0);
        rst = 1'b0;
        step();
        check("post_rst_lock_err", lock_err, 1'b0);
        check("post_rst_b_data", b_data, 16'h0000);

        // fill through W, sweep adjacent pairs
        for (int i = 0; i < 8; i++) begin
            w_en = 1'b1; w_sel = 3'(i); w_data = 16'h0123 + 16'h1111 * 16'(i);
            step();
        end
        idle();
        for (int i = 0; i < 8; i++) exp_q.push_back(16'h0123 + 16'h1111 * 16'(i));
        for (int i = 0; i < 7; i++) begin
            a_sel = 3'(i); b_sel = 3'(i + 1);
            #1;
            exp_v = exp_q[i];
            check($sformatf("w_fill_a%0d", i), a_data, exp_v);
            check($sformatf("w_fill_nb_a%0d", i), nb_a_data, exp_v);
            check($sformatf("w_fill_z_a%0d", i), z_a_data, (i == 0) ? 16'h0000 : exp_v);
            exp_v = exp_q[i + 1];
            check($sformatf("w_fill_b%0d", i + 1), b_data, exp_v);
        end
        exp_q.delete();

        // fill through X
        for (int i = 0; i < 8; i++) begin
            x_en = 1'b1; x_sel = 3'(i); x_data = 16'hA000 + 16'(i);
            step();
            exp_q.push_back(16'hA000 + 16'(i));
        end
        idle();
        for (int i = 0; i < 7; i++) begin
            a_sel = 3'(i); b_sel = 3'(i + 1);
            #1;
            exp_v = exp_q.pop_front();
            check($sformatf("x_fill_a%0d", i), a_data, exp_v);
            check($sformatf("x_fill_b%0d", i + 1), b_data, exp_q[0]);
        end
        exp_q.delete();

        // W/X collision on reg5
        a_sel = 3'd5;
        w_en = 1'b1; w_sel = 3'd5; w_data = 16'h5678;
        x_en = 1'b1; x_sel = 3'd5; x_data = 16'hAAAA;
        #1;
        check("prio_bypass_a", a_data, 16'h5678);
        check("prio_nobypass_a", nb_a_data, 16'hA005);
        step();
        idle();
        check("prio_stored_a", a_data, 16'h5678);
        check("prio_stored_nb_a", nb_a_data, 16'h5678);

        // W and X to different registers
        w_en = 1'b1; w_sel = 3'd4; w_data = 16'h4444;
        x_en = 1'b1; x_sel = 3'd2; x_data = 16'h2222;
        step();
        idle();
        a_sel = 3'd4; b_sel = 3'd2;
        #1;
        check("split_w_reg4", a_data, 16'h4444);
        check("split_x_reg2", b_data, 16'h2222);

        // same-cycle bypass on both ports
        a_sel = 3'd1; b_sel = 3'd6;
        w_en = 1'b1; w_sel = 3'd1; w_data = 16'hF000;
        x_en = 1'b1; x_sel = 3'd6; x_data = 16'h0BEE;
        #1;
        check("bypass_w_a", a_data, 16'hF000);
        check("bypass_x_b", b_data, 16'h0BEE);
        check("nobypass_a_old", nb_a_data, 16'hA001);
        check("nobypass_b_old", nb_b_data, 16'hA006);
        step();
        idle();
        check("nobypass_a_new", nb_a_data, 16'hF000);
        check("nobypass_b_new", nb_b_data, 16'h0BEE);

        // scoreboard on reg3
        a_sel = 3'd3; b_sel = 3'd3;
        lock_en = 1'b1; lock_sel = 3'd3;
        #1;
        check("lock_no_same_cycle_busy", b_busy, 1'b0);
        step();
        idle();
        check("lock_b_busy", b_busy, 1'b1);
        check("lock_first_no_err", lock_err, 1'b0);
        lock_en = 1'b1; lock_sel = 3'd3;
        step();
        idle();
        check("relock_err", lock_err, 1'b1);
        check("relock_a_busy", a_busy, 1'b1);
        step();
        check("relock_err_one_cycle", lock_err, 1'b0);
        x_en = 1'b1; x_sel = 3'd3; x_data = 16'h0333;
        step();
        idle();
        check("x_clears_busy", b_busy, 1'b0);
        check("x_clears_data", a_data, 16'h0333);
        lock_en = 1'b1; lock_sel = 3'd3;
        w_en = 1'b1; w_sel = 3'd3; w_data = 16'h0777;
        step();
        idle();
        check("lock_write_busy", a_busy, 1'b1);
        check("lock_write_data", b_data, 16'h0777);
        check("lock_write_no_err", lock_err, 1'b0);
        lock_en = 1'b1; lock_sel = 3'd3;
        x_en = 1'b1; x_sel = 3'd3; x_data = 16'h0888;
        step();
        idle();
        check("relock_with_clear_no_err", lock_err, 1'b0);
        check("relock_with_clear_busy", b_busy, 1'b1);
        lock_en = 1'b1; lock_sel = 3'd3;
        w_en = 1'b1; w_sel = 3'd2; w_data = 16'h0999;
        step();
        idle();
        check("relock_other_write_err", lock_err, 1'b1);

        // zero register
        a_sel = 3'd0; b_sel = 3'd0;
        w_en = 1'b1; w_sel = 3'd0; w_data = 16'hFFFF;
        lock_en = 1'b1; lock_sel = 3'd0;
        #1;
        check("zero_bypass_a", z_a_data, 16'h0000);
        step();
        idle();
        check("zero_a_data", z_a_data, 16'h0000);
        check("zero_a_busy", z_a_busy, 1'b0);
        check("nonzero_reg0_data", a_data, 16'hFFFF);
        check("nonzero_reg0_busy", b_busy, 1'b1);
        lock_en = 1'b1; lock_sel = 3'd0;
        step();
        idle();
        check("zero_lock_no_err", z_lock_err, 1'b0);
        check("nonzero_reg0_relock_err", lock_err, 1'b1);
        check("zero_b_busy", z_b_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_bank.md
# regfile_bank

Parametrised successor to the 8×16 two-read/one-write register file.
- Storage: 2^ADDR_W registers of DATA_W bits, two asynchronous read ports and two synchronous write ports with fixed priority.
- Optional write-to-read bypass and an optional hard-wired zero register.
- Per-register busy scoreboard: the datapath sequencer reserves a destination before its result arrives, and the scoreboard tracks those reservations.
- Sits between the instruction decoder (read selects, lock requests) and the ALU/load writeback paths.

## Interface
- DATA_W, 16: register width in bits.
- ADDR_W, 3: select width; DEPTH = 2^ADDR_W registers.
- BYPASS, 1: 1 = reads return same-cycle write data (write-first); 0 = reads return stored value.
- ZERO_R0, 0: 1 = register 0 reads 0, ignores writes and locks.

- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_sel  in  ADDR_W  read port A select.
- a_data  out  DATA_W  read port A data (combinational).
- a_busy  out  1  scoreboard bit of a_sel (combinational).
- b_sel  in  ADDR_W  read port B select.
- b_data  out  DATA_W  read port B data (combinational).
- b_busy  out  1  scoreboard bit of b_sel (combinational).
- w_en  in  1  write port W enable (high priority, ALU writeback).
- w_sel  in  ADDR_W  write port W address.
- w_data  in  DATA_W  write port W data.
- x_en  in  1  write port X enable (low priority, load writeback).
- x_sel  in  ADDR_W  write port X address.
- x_data  in  DATA_W  write port X data.
- lock_en  in  1  reserve register lock_sel (set its busy bit).
- lock_sel  in  ADDR_W  register to reserve.
- lock_err  out  1  registered one-cycle pulse: lock requested on an already-busy register.

## Operation
**Reset**
- All registers = 0, all busy bits = 0, lock_err = 0.
- Effective immediately, independent of clk.

**Write ports**
- On a rising edge with w_en = 1, reg[w_sel] ← w_data.
- On a rising edge with x_en = 1, reg[x_sel] ← x_data.
- Both enabled with w_sel == x_sel: W wins and X is dropped.

**Scoreboard**
- Any accepted write clears busy[addr].
- lock_en sets busy[lock_sel].
- Lock and write to the same address in the same cycle: lock wins, busy ends 1 and the data is still written.
- lock_en to a register already busy, and not cleared by a write that same cycle: busy stays 1 and lock_err = 1 on the next cycle.

**Reads**
- a_data = reg[a_sel] and b_data = reg[b_sel], combinational.
- BYPASS = 1: if the select matches an enabled write address, output that write's data, applying W-over-X priority.
- a_busy/b_busy show the current-cycle busy bit, with no bypass of same-cycle lock or clear.

**Zero register (ZERO_R0 = 1)**
- Register 0 is never written or locked.
- Reads return 0 and busy reads 0.
- Lock on register 0 is ignored and does not raise lock_err.

**Width**
- Data is stored verbatim: no extension, no truncation.
- Selects cover all 2^ADDR_W entries, so no out-of-range case exists.

## Timing
- Read latency: 0 cycles (combinational from selects and storage).
- Write latency: data is visible on read one edge after the write when BYPASS = 0, and in the same cycle when BYPASS = 1.
- Busy update latency: one edge. lock at edge N gives busy = 1 from N onward; a write at edge M > N gives busy = 0 from M.
- lock_err is high for exactly one cycle, the cycle after the offending edge, and is otherwise 0.
- Reset asserted mid-operation: all state is cleared asynchronously. Writes and locks presented while rst = 1 are discarded, and lock_err is forced to 0.
- No handshake stalls: every request is accepted every cycle.

## Test plan
- **Reset:** assert rst with reg3 previously written 16'h3456 -> a_data/b_data = 0, a_busy = b_busy = 0, lock_err = 0 while rst = 1 and after release.
- **Fill/readback:** write 16'h0123 + 16'h1111·i to reg i (i = 0..7) on W, then sweep a_sel/b_sel over pairs (0,1)…(6,7) -> each read returns its written value. Repeat via X port.
- **Priority:** same edge, W writes reg5 = 16'h5678 and X writes reg5 = 16'hAAAA -> reg5 = 16'h5678. Different addresses reg4/reg2 -> both written.
- **Bypass:** BYPASS = 1, a_sel = 1, W writes 16'hF000 to reg1 -> a_data = 16'hF000 in the same cycle. With BYPASS = 0, a_data keeps its old value until after the edge.
- **Scoreboard:**
  - lock reg3 -> b_busy = 1 with b_sel = 3.
  - Lock reg3 again -> lock_err pulses one cycle.
  - X writes reg3 -> busy clears.
  - Lock and write reg3 on the same edge -> busy = 1 and data written.
- **Zero register:** ZERO_R0 = 1, write 16'hFFFF and lock reg0 -> a_data = 0, a_busy = 0, lock_err = 0.
